// File: rtl/als_spi_controller.sv
// ---------------------------------------------------------------------------
// als_spi_controller
//
// Master-side sequencer for the 3-wire SPI ambient light sensor pmod. The
// sensor's ADC shifts out a frame of LEAD_ZEROS leading zeros, 8 data bits
// MSB first and trailing zeros on SCLK falling edges. This block divides the
// system clock to make SCLK, drives CS_N, samples SDATA on SCLK rising edges,
// checks the leading zeros and hands one 8-bit sample per frame to the
// downstream logic with a single-cycle strobe.
//
// Ports:
//   clk        in   system clock, everything on the rising edge
//   reset      in   asynchronous active-high reset
//   start      in   request one frame (only looked at while idle)
//   auto_en    in   free-run, start a frame whenever idle
//   SDATA      in   serial data from the pmod (asynchronous to clk)
//   SCLK       out  serial clock to the pmod, registered, idles high
//   CS_N       out  chip select, active low, registered
//   data       out  last captured 8-bit sample, holds between strobes
//   data_valid out  one-cycle strobe when data/frame_err update
//   frame_err  out  a leading bit of the last frame was 1
//   busy       out  high from frame accept until the quiet gap ends
// ---------------------------------------------------------------------------
module als_spi_controller #(
  parameter int HALF_PERIOD  = 50,
  parameter int FRAME_BITS   = 16,
  parameter int LEAD_ZEROS   = 3,
  parameter int QUIET_CYCLES = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       auto_en,
  input  logic       SDATA,
  output logic       SCLK,
  output logic       CS_N,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV_W   = $clog2(HALF_PERIOD);
  localparam int HALF_W  = $clog2(2 * FRAME_BITS + 1);
  localparam int BIT_W   = $clog2(FRAME_BITS + 1);
  localparam int QUIET_W = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(HALF_PERIOD - 1);
  localparam logic [HALF_W-1:0]  HALF_LAST  = HALF_W'(2 * FRAME_BITS);
  localparam logic [BIT_W-1:0]   DATA_FIRST = BIT_W'(LEAD_ZEROS);
  localparam logic [BIT_W-1:0]   DATA_END   = BIT_W'(LEAD_ZEROS + 8);
  localparam logic [QUIET_W-1:0] QUIET_LAST = QUIET_W'(QUIET_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, QUIET} state_t;

  state_t state, next_state;

  logic               sdata_meta, sdata_sync;
  logic [DIV_W-1:0]   div_cnt;
  logic [HALF_W-1:0]  half_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [QUIET_W-1:0] quiet_cnt;
  logic [7:0]         shift_reg;
  logic               err_flag;

  logic accept, half_tick, frame_done, rise_now, quiet_done;

  // half_cnt counts completed SCLK half periods since CS_N fell. Once all
  // 2*FRAME_BITS halves are done, the next half-period boundary ends the
  // frame instead of producing another falling edge, so SCLK stays high.
  assign accept     = (state == IDLE) && (start || auto_en);
  assign half_tick  = (state == SHIFT) && (div_cnt == DIV_LAST);
  assign frame_done = half_tick && (half_cnt == HALF_LAST);
  assign rise_now   = half_tick && !frame_done && !SCLK;
  assign quiet_done = (state == QUIET) && (quiet_cnt == QUIET_LAST);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept)     next_state = SHIFT;
      SHIFT:   if (frame_done) next_state = QUIET;
      QUIET:   if (quiet_done) next_state = IDLE;
      default:                 next_state = IDLE;
    endcase
  end

  // SDATA changes relative to SCLK, not clk, so it is resynchronised first.
  // The two flops cost two clk cycles of latency, which fits inside the
  // half period between the sensor's falling-edge update and our capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sdata_meta <= 1'b0;
      sdata_sync <= 1'b0;
    end else begin
      sdata_meta <= SDATA;
      sdata_sync <= sdata_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      SCLK       <= 1'b1;
      CS_N       <= 1'b1;
      data       <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      div_cnt    <= '0;
      half_cnt   <= '0;
      bit_cnt    <= '0;
      quiet_cnt  <= '0;
      shift_reg  <= 8'h00;
      err_flag   <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            CS_N      <= 1'b0;
            SCLK      <= 1'b1;
            div_cnt   <= '0;
            half_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= 8'h00;
            err_flag  <= 1'b0;
          end
        end
        SHIFT: begin
          if (half_tick) begin
            div_cnt <= '0;
            if (frame_done) begin
              CS_N       <= 1'b1;
              data       <= shift_reg;
              frame_err  <= err_flag;
              data_valid <= 1'b1;
              quiet_cnt  <= '0;
            end else begin
              SCLK     <= ~SCLK;
              half_cnt <= half_cnt + 1'b1;
              // bit_cnt is the frame bit index captured on this rising edge;
              // bits past the data byte are trailing zeros and are dropped.
              if (rise_now) begin
                bit_cnt <= bit_cnt + 1'b1;
                if (bit_cnt < DATA_FIRST) begin
                  err_flag <= err_flag | sdata_sync;
                end else if (bit_cnt < DATA_END) begin
                  shift_reg <= {shift_reg[6:0], sdata_sync};
                end
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        QUIET: begin
          if (!quiet_done) begin
            quiet_cnt <= quiet_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_als_spi_controller.sv
// ---------------------------------------------------------------------------
// tb_als_spi_controller
//
// Two controllers run side by side: one with the default 50-cycle half period
// and one with the minimum half period of 4. A sensor model per instance
// shifts out the frame word chosen for that frame on SCLK falling edges. A
// frame-level reference model tracks how many clk cycles have passed since
// each frame was accepted and derives CS_N, SCLK, busy, data_valid, data and
// frame_err from that count; every cycle those are compared against the DUT.
// ---------------------------------------------------------------------------
module tb_als_spi_controller;

  localparam int FB = 16;
  localparam int LZ = 3;
  localparam int QC = 100;
  localparam int H0 = 50;
  localparam int H1 = 4;

  logic clk = 1'b0;
  logic reset;
  logic start_in [2];
  logic auto_in  [2];
  logic sdata_in [2];

  logic       sclk0, cs_n0, valid0, err0, busy0;
  logic       sclk1, cs_n1, valid1, err1, busy1;
  logic [7:0] data0, data1;

  logic       sclk_a  [2];
  logic       cs_a    [2];
  logic       valid_a [2];
  logic       err_a   [2];
  logic       busy_a  [2];
  logic [7:0] data_a  [2];

  assign sclk_a[0] = sclk0;   assign sclk_a[1] = sclk1;
  assign cs_a[0]   = cs_n0;   assign cs_a[1]   = cs_n1;
  assign valid_a[0] = valid0; assign valid_a[1] = valid1;
  assign err_a[0]  = err0;    assign err_a[1]  = err1;
  assign busy_a[0] = busy0;   assign busy_a[1] = busy1;
  assign data_a[0] = data0;   assign data_a[1] = data1;

  als_spi_controller #(.HALF_PERIOD(H0), .FRAME_BITS(FB), .LEAD_ZEROS(LZ), .QUIET_CYCLES(QC)) dut0 (
    .clk(clk), .reset(reset), .start(start_in[0]), .auto_en(auto_in[0]), .SDATA(sdata_in[0]),
    .SCLK(sclk0), .CS_N(cs_n0), .data(data0), .data_valid(valid0), .frame_err(err0), .busy(busy0)
  );

  als_spi_controller #(.HALF_PERIOD(H1), .FRAME_BITS(FB), .LEAD_ZEROS(LZ), .QUIET_CYCLES(QC)) dut1 (
    .clk(clk), .reset(reset), .start(start_in[1]), .auto_en(auto_in[1]), .SDATA(sdata_in[1]),
    .SCLK(sclk1), .CS_N(cs_n1), .data(data1), .data_valid(valid1), .frame_err(err1), .busy(busy1)
  );

  initial forever #5 clk = ~clk;

  int n_total;
  int n_bad;

  // reference model state
  bit          m_active   [2];
  int          m_t        [2];
  logic [7:0]  m_data     [2];
  logic        m_err      [2];
  logic [7:0]  m_pend_data[2];
  logic        m_pend_err [2];
  logic [15:0] cur_word   [2];
  logic [15:0] q0[$];
  logic [15:0] q1[$];

  // observed statistics
  int         frames_started[2];
  int         strobe_cnt    [2];
  int         last_low_len  [2];
  int         last_high_len [2];
  int         rises         [2];
  logic [7:0] last_strobe   [2];
  logic [7:0] prev_strobe   [2];

  function automatic int halfOf(input int g);
    return (g == 0) ? H0 : H1;
  endfunction

  function automatic logic [15:0] randWord(input bit allow_err);
    logic [15:0] w;
    w = 16'($urandom);
    if (!allow_err || $urandom_range(0, 3) != 0) w[15:13] = 3'b000;
    return w;
  endfunction

  function automatic logic [15:0] makeWord(input logic [2:0] lead, input logic [7:0] d);
    return {lead, d, 5'($urandom)};
  endfunction

  function automatic logic [15:0] nextWord(input int g);
    if (g == 0) begin
      if (q0.size() > 0) return q0.pop_front();
    end else begin
      if (q1.size() > 0) return q1.pop_front();
    end
    return randWord(1'b1);
  endfunction

  task automatic checkOutput(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s dut%0d: got %0h expected %0h at %0t", name, g, act, exp, $time);
    end
  endtask

  // Frame-level model: a frame occupies (2*FB+1)*H cycles with CS_N low,
  // then QC quiet cycles; the sample is the data byte of the word sent.
  task automatic modelRun();
    bit          was;
    int          fl;
    logic [15:0] w;
    forever begin
      @(posedge clk or posedge reset);
      for (int g = 0; g < 2; g++) begin
        if (reset) begin
          m_active[g] = 1'b0;
          m_t[g]      = 0;
          m_data[g]   = 8'h00;
          m_err[g]    = 1'b0;
        end else begin
          fl  = (2 * FB + 1) * halfOf(g);
          was = m_active[g];
          if (was) begin
            if (m_t[g] == fl + QC - 1) begin
              m_active[g] = 1'b0;
            end else begin
              m_t[g]++;
              if (m_t[g] == fl) begin
                m_data[g] = m_pend_data[g];
                m_err[g]  = m_pend_err[g];
              end
            end
          end else if (start_in[g] || auto_in[g]) begin
            w              = nextWord(g);
            cur_word[g]    = w;
            m_pend_data[g] = w[FB-1-LZ -: 8];
            m_pend_err[g]  = |w[FB-1 -: LZ];
            m_active[g]    = 1'b1;
            m_t[g]         = 0;
          end
        end
      end
    end
  endtask

  // Sensor model: drives frame bit k after the (k+1)-th SCLK falling edge.
  task automatic pmodRun(input int g);
    logic        prev_cs, prev_sclk;
    int          fi;
    logic [15:0] w;
    prev_cs = 1'b1; prev_sclk = 1'b1; fi = 0; w = '0;
    forever begin
      @(posedge clk);
      #1;
      if (prev_cs === 1'b1 && cs_a[g] === 1'b0) begin
        fi = 0;
        w  = cur_word[g];
        sdata_in[g] = 1'b0;
      end else if (cs_a[g] === 1'b0 && prev_sclk === 1'b1 && sclk_a[g] === 1'b0 && fi < FB) begin
        sdata_in[g] = w[FB-1-fi];
        fi++;
      end else if (cs_a[g] === 1'b1) begin
        sdata_in[g] = 1'b0;
      end
      prev_cs   = cs_a[g];
      prev_sclk = sclk_a[g];
    end
  endtask

  task automatic compareRun();
    logic pc[2], ps[2];
    int   low_run[2], high_run[2];
    int   fl, h;
    logic e_cs, e_sclk, e_busy, e_valid;
    for (int g = 0; g < 2; g++) begin
      pc[g] = 1'b1; ps[g] = 1'b1; low_run[g] = 0; high_run[g] = 0;
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        h  = halfOf(g);
        fl = (2 * FB + 1) * h;
        if (!m_active[g]) begin
          e_cs = 1'b1; e_sclk = 1'b1; e_busy = 1'b0; e_valid = 1'b0;
        end else if (m_t[g] < fl) begin
          e_cs = 1'b0; e_sclk = ((m_t[g] / h) % 2 == 0); e_busy = 1'b1; e_valid = 1'b0;
        end else begin
          e_cs = 1'b1; e_sclk = 1'b1; e_busy = 1'b1; e_valid = (m_t[g] == fl);
        end
        checkOutput("cs_n", g, 32'(cs_a[g]), 32'(e_cs));
        checkOutput("sclk", g, 32'(sclk_a[g]), 32'(e_sclk));
        checkOutput("busy", g, 32'(busy_a[g]), 32'(e_busy));
        checkOutput("data_valid", g, 32'(valid_a[g]), 32'(e_valid));
        checkOutput("data", g, 32'(data_a[g]), 32'(m_data[g]));
        checkOutput("frame_err", g, 32'(err_a[g]), 32'(m_err[g]));

        if (cs_a[g] === 1'b0) begin
          if (pc[g] === 1'b1) begin
            frames_started[g]++;
            last_high_len[g] = high_run[g];
            rises[g]   = 0;
            low_run[g] = 0;
          end
          low_run[g]++;
          if (ps[g] === 1'b0 && sclk_a[g] === 1'b1) rises[g]++;
        end else begin
          if (pc[g] === 1'b0) begin
            last_low_len[g] = low_run[g];
            high_run[g] = 0;
          end
          high_run[g]++;
        end
        if (valid_a[g] === 1'b1) begin
          strobe_cnt[g]++;
          prev_strobe[g] = last_strobe[g];
          last_strobe[g] = data_a[g];
        end
        pc[g] = cs_a[g];
        ps[g] = sclk_a[g];
      end
    end
  endtask

  task automatic pulseStart(input int g);
    @(negedge clk);
    start_in[g] = 1'b1;
    @(negedge clk);
    start_in[g] = 1'b0;
  endtask

  task automatic applyStimulus(input int g, input logic [15:0] w);
    if (g == 0) q0.push_back(w); else q1.push_back(w);
    pulseStart(g);
  endtask

  task automatic waitIdle(input int g, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (busy_a[g] !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_timeout", g, 32'(n < budget), 32'd1);
  endtask

  task automatic waitFrames(input int g, input int target, input int budget);
    int n;
    n = 0;
    while (frames_started[g] < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("frame_timeout", g, 32'(n < budget), 32'd1);
  endtask

  task automatic waitStrobe(input int g, input int target, input int budget);
    int n;
    n = 0;
    while (strobe_cnt[g] < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("strobe_timeout", g, 32'(n < budget), 32'd1);
  endtask

  initial begin
    int fb, sb, n, g, hold, mode;
    n_total = 0;
    n_bad   = 0;
    reset   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_in[i] = 1'b0; auto_in[i] = 1'b0; sdata_in[i] = 1'b0;
      m_active[i] = 1'b0; m_t[i] = 0; m_data[i] = 8'h00; m_err[i] = 1'b0;
      m_pend_data[i] = 8'h00; m_pend_err[i] = 1'b0; cur_word[i] = '0;
      frames_started[i] = 0; strobe_cnt[i] = 0; last_low_len[i] = 0;
      last_high_len[i] = 0; rises[i] = 0; last_strobe[i] = 8'h00; prev_strobe[i] = 8'h00;
    end
    fork
      modelRun();
      pmodRun(0);
      pmodRun(1);
      compareRun();
    join_none

    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_cs_n", 0, 32'(cs_n0), 32'd1);
    checkOutput("rst_sclk", 0, 32'(sclk0), 32'd1);
    checkOutput("rst_data", 0, 32'(data0), 32'd0);
    checkOutput("rst_busy", 0, 32'(busy0), 32'd0);
    checkOutput("rst_valid", 0, 32'(valid0), 32'd0);

    $display("[TB] single frame 0xFB");
    applyStimulus(0, makeWord(3'b000, 8'hFB));
    waitIdle(0, 4000);
    checkOutput("fb_model", 0, 32'(m_data[0]), 32'hFB);
    checkOutput("fb_data", 0, 32'(data0), 32'hFB);
    checkOutput("fb_err", 0, 32'(err0), 32'd0);
    checkOutput("fb_cs_low_len", 0, 32'(last_low_len[0]), 32'd1650);
    checkOutput("fb_rises", 0, 32'(rises[0]), 32'd16);
    checkOutput("fb_strobes", 0, 32'(strobe_cnt[0]), 32'd1);

    $display("[TB] free-run 0x99 then 0x81, auto_en dropped mid-frame");
    fb = frames_started[0];
    sb = strobe_cnt[0];
    q0.push_back(makeWord(3'b000, 8'h99));
    q0.push_back(makeWord(3'b000, 8'h81));
    @(negedge clk);
    auto_in[0] = 1'b1;
    waitFrames(0, fb + 2, 6000);
    repeat (200) @(negedge clk);
    auto_in[0] = 1'b0;
    waitIdle(0, 4000);
    repeat (30) @(negedge clk);
    checkOutput("auto_frames", 0, 32'(frames_started[0]), 32'(fb + 2));
    checkOutput("auto_strobes", 0, 32'(strobe_cnt[0]), 32'(sb + 2));
    checkOutput("auto_first", 0, 32'(prev_strobe[0]), 32'h99);
    checkOutput("auto_second", 0, 32'(last_strobe[0]), 32'h81);
    checkOutput("auto_gap", 0, 32'(last_high_len[0]), 32'd101);
    checkOutput("auto_idle_cs", 0, 32'(cs_n0), 32'd1);

    $display("[TB] leading-zero violation then clean frame");
    applyStimulus(0, makeWord(3'b010, 8'hAB));
    waitIdle(0, 4000);
    checkOutput("lz_data", 0, 32'(data0), 32'hAB);
    checkOutput("lz_err", 0, 32'(err0), 32'd1);
    applyStimulus(0, makeWord(3'b000, 8'h10));
    waitIdle(0, 4000);
    checkOutput("clean_data", 0, 32'(data0), 32'h10);
    checkOutput("clean_err", 0, 32'(err0), 32'd0);

    $display("[TB] reset at 10th SCLK rising edge");
    applyStimulus(0, randWord(1'b0));
    n = 0;
    while (rises[0] < 10 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rise10_timeout", 0, 32'(n < 3000), 32'd1);
    sb = strobe_cnt[0];
    #1 reset = 1'b1;
    #1;
    checkOutput("abort_cs_n", 0, 32'(cs_n0), 32'd1);
    checkOutput("abort_sclk", 0, 32'(sclk0), 32'd1);
    checkOutput("abort_data", 0, 32'(data0), 32'd0);
    checkOutput("abort_valid", 0, 32'(valid0), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_no_strobe", 0, 32'(strobe_cnt[0]), 32'(sb));
    applyStimulus(0, makeWord(3'b000, 8'h81));
    waitIdle(0, 4000);
    checkOutput("after_abort_data", 0, 32'(data0), 32'h81);

    $display("[TB] start pulses during SHIFT and QUIET are ignored");
    fb = frames_started[0];
    sb = strobe_cnt[0];
    applyStimulus(0, randWord(1'b1));
    repeat (300) @(negedge clk);
    pulseStart(0);
    waitStrobe(0, sb + 1, 3000);
    repeat (20) @(negedge clk);
    pulseStart(0);
    waitIdle(0, 4000);
    repeat (50) @(negedge clk);
    checkOutput("ign_frames", 0, 32'(frames_started[0]), 32'(fb + 1));
    checkOutput("ign_strobes", 0, 32'(strobe_cnt[0]), 32'(sb + 1));
    checkOutput("ign_idle_cs", 0, 32'(cs_n0), 32'd1);

    $display("[TB] minimum half period with 0xAB");
    applyStimulus(1, makeWord(3'b000, 8'hAB));
    waitIdle(1, 1000);
    checkOutput("h4_data", 1, 32'(data1), 32'hAB);
    checkOutput("h4_err", 1, 32'(err1), 32'd0);
    checkOutput("h4_cs_low_len", 1, 32'(last_low_len[1]), 32'd132);
    checkOutput("h4_rises", 1, 32'(rises[1]), 32'd16);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 10; i++) begin
      g = (i < 2) ? 0 : 1;
      repeat ($urandom_range(0, 10)) @(negedge clk);
      mode = $urandom_range(0, 2);
      if (mode == 0) begin
        applyStimulus(g, randWord(1'b1));
      end else begin
        hold = (g == 0) ? $urandom_range(1, 2500) : $urandom_range(1, 400);
        @(negedge clk);
        if (mode == 1) start_in[g] = 1'b1; else auto_in[g] = 1'b1;
        repeat (hold) @(negedge clk);
        start_in[g] = 1'b0;
        auto_in[g]  = 1'b0;
      end
      waitIdle(g, 5000);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/als_spi_controller.md
Name: als_spi_controller

Overview:
- Master-side sequencer for the 3-wire SPI light-sensor pmod: ADC frame of 3 leading zeros, 8 data bits MSB first, then trailing zeros, shifted out on SCLK falling edges.
- Divides the system clock to generate SCLK and drives CS_N. Samples SDATA, checks the leading zeros, and delivers one 8-bit sample per frame with a single-cycle valid strobe.
- Sits between the pmod pins and the display/processing logic. Frames start on request or free-run.

Parameters:
HALF_PERIOD, 50, clk cycles per SCLK half period (100 MHz clk -> 1 MHz SCLK); legal range >= 4
FRAME_BITS, 16, SCLK cycles per frame
LEAD_ZEROS, 3, leading zero bits before data MSB
QUIET_CYCLES, 100, clk cycles CS_N held high after a frame before the next may start

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request one frame; sampled only in IDLE
auto_en  in  1  free-run: start a new frame whenever IDLE
SDATA  in  1  serial data from pmod
SCLK  out  1  serial clock to pmod, registered
CS_N  out  1  chip select, active low, registered
data  out  8  last captured sample
data_valid  out  1  one-cycle strobe, data updated
frame_err  out  1  leading-zero violation in last frame; valid with data_valid
busy  out  1  high from frame accept through end of QUIET

Behaviour:
- Reset (async, immediate): CS_N=1, SCLK=1, data=0, data_valid=0, frame_err=0, busy=0, state=IDLE, all counters 0. Reset mid-frame aborts with no strobe and no data update.
- SDATA passes through a 2-flop synchronizer before use.
- States: IDLE, SHIFT, QUIET.
- IDLE -> SHIFT when start|auto_en is sampled high (cycle A). At A+1: CS_N=0, SCLK=1, busy=1, divider and bit counters at 0.
- SHIFT timing, in clk cycles after CS_N falls:
  - SCLK toggles every HALF_PERIOD cycles: falling edges at H, 3H, ...; rising edges at 2H, 4H, ..., 2*FRAME_BITS*H.
  - At rising edge k (1..FRAME_BITS), the synchronized SDATA is captured as frame bit k-1.
  - Bits LEAD_ZEROS .. LEAD_ZEROS+7 shift into the data shift register MSB first.
  - Any 1 captured in bits 0..LEAD_ZEROS-1 sets the internal error flag. Trailing bits are ignored.
- Frame end: H cycles after the last rising edge (cycle (2*FRAME_BITS+1)*H after CS_N fall):
  - CS_N=1, SCLK stays 1.
  - data <= shift register, frame_err <= error flag, data_valid=1 for exactly that cycle.
  - Enter QUIET.
- QUIET: counts QUIET_CYCLES clk cycles, busy=1, then IDLE (busy=0). A new frame can be accepted in the first IDLE cycle.
- start or auto_en asserted outside IDLE is ignored, with no queueing. start held high continuously behaves like auto_en.
- Deasserting auto_en mid-frame has no effect on the current frame; no further frame follows.
- data and frame_err hold their values between strobes.
- Default-parameter frame length is 33*50 = 1650 clk cycles with CS_N low.

Test Plan:
- Reset, then start pulse for 1 cycle with the pmod model sending 8'hFB -> CS_N low 1650 cycles, 16 SCLK rising edges, data=8'hFB, data_valid high 1 cycle, frame_err=0, busy falls QUIET_CYCLES cycles after CS_N rises.
- auto_en=1, model sends 8'h99 then 8'h81 -> two frames, CS_N high gap of QUIET_CYCLES+1 cycles between them, strobes carry 8'h99 then 8'h81.
- Model drives leading bit 1 = 1 with data 8'hAB -> data=8'hAB, frame_err=1 on the strobe. The next clean frame with 8'h10 -> frame_err=0.
- Assert reset at the 10th SCLK rising edge -> CS_N=1, SCLK=1 same cycle, no data_valid, data=0. A subsequent start yields a correct frame with 8'h81.
- start pulsed during SHIFT and again during QUIET -> exactly one frame and one data_valid. auto_en dropped mid-frame -> frame completes and IDLE holds CS_N=1.
- HALF_PERIOD=4 (minimum) with 8'hAB -> data=8'hAB, confirming synchronizer latency margin.
